// File: rtl/vga_console_pkg.sv
// ============================================================================
// Module : vga_console_pkg
// Purpose: Shared types and constants for the VGA console writer: the
//          controller state encoding and the control codes it interprets.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_console_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      MODE   = 3'd1,
      WRITE  = 3'd2,
      SCR_RD = 3'd3,
      SCR_WR = 3'd4,
      FILL   = 3'd5,
      CLEAR  = 3'd6
   } console_state_t;

   localparam logic [7:0] CH_BS = 8'h08;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_CR = 8'h0D;

endpackage

`default_nettype wire

// File: rtl/vga_console_writer.sv
// ============================================================================
// Module : vga_console_writer
// Purpose: Turns a byte stream of characters into writes on the VGA text RAM
//          port. Keeps a cursor, handles CR/LF/BS, wraps lines, scrolls by
//          copying rows up through the RAM port, clears the screen and
//          writes the display mode register.
// Ports  : clk_sys, rst (async, active low)
//          char_valid/char_data/char_ready : byte source handshake
//          clear_req, mode_req/mode_val    : one-cycle request pulses
//          vga_ms/vga_wren/vga_a/vga_din   : VGA port drive
//          vga_dout                        : RAM read data (1-cycle latency)
//          busy, cursor_row, cursor_col    : status
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_console_writer
   import vga_console_pkg::*;
#(
   parameter int          COLS      = 32,
   parameter int          ROWS      = 16,
   parameter logic [11:0] BASE_ADDR = 12'h000,
   parameter logic [7:0]  BLANK     = 8'h20
) (
   input  logic                    clk_sys,
   input  logic                    rst,
   input  logic                    char_valid,
   input  logic [7:0]              char_data,
   output logic                    char_ready,
   input  logic                    clear_req,
   input  logic                    mode_req,
   input  logic                    mode_val,
   output logic                    vga_ms,
   output logic                    vga_wren,
   output logic [11:0]             vga_a,
   output logic [7:0]              vga_din,
   input  logic [7:0]              vga_dout,
   output logic                    busy,
   output logic [$clog2(ROWS)-1:0] cursor_row,
   output logic [$clog2(COLS)-1:0] cursor_col
);

   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);

   localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
   localparam logic [CW-1:0] LAST_COL   = CW'(COLS - 1);
   localparam logic [11:0]   LAST_CNT   = 12'(COLS * ROWS - 1);
   localparam logic [11:0]   COLS_12    = 12'(COLS);
   localparam logic [11:0]   FILL_START = 12'((ROWS - 1) * COLS);

   if ((COLS & (COLS - 1)) != 0 || COLS < 2) begin : g_bad_cols
      $error("COLS must be a power of two and at least 2");
   end
   if (ROWS < 2) begin : g_bad_rows
      $error("ROWS must be at least 2");
   end
   if (int'(BASE_ADDR) + COLS * ROWS > 4096) begin : g_bad_size
      $error("BASE_ADDR + COLS*ROWS exceeds the 12-bit address space");
   end

   console_state_t state, next_state;

   logic [RW-1:0] row;
   logic [CW-1:0] col;
   logic [11:0]   cnt;        // scroll source / fill / clear offset
   logic [11:0]   wr_addr;
   logic [7:0]    wr_data;
   logic          wr_adv;     // WRITE advances the cursor (printable, not BS)
   logic          clear_pend;
   logic          mode_pend;
   logic          mode_q;
   logic          accept;

   // COLS is a power of two, so row*COLS+col is just the concatenation.
   logic [11:0] cur_pos;
   logic [11:0] bs_pos;
   assign cur_pos = 12'({row, col});
   assign bs_pos  = 12'({row, col - CW'(1)});

   // Gated with rst so the handshake is held low while reset is applied.
   assign char_ready = rst && (state == IDLE) && !clear_pend && !mode_pend;
   assign accept     = char_valid && char_ready;
   assign busy       = (state != IDLE);
   assign cursor_row = row;
   assign cursor_col = col;

   always_ff @(posedge clk_sys or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      vga_ms     = 1'b0;
      vga_wren   = 1'b0;
      vga_a      = 12'h000;
      vga_din    = 8'h00;
      case (state)
         IDLE: begin
            if (clear_pend) begin
               next_state = CLEAR;
            end else if (mode_pend) begin
               next_state = MODE;
            end else if (accept) begin
               case (char_data)
                  CH_CR: next_state = IDLE;
                  CH_LF: next_state = (row == LAST_ROW) ? SCR_RD : IDLE;
                  CH_BS: next_state = (col != '0) ? WRITE : IDLE;
                  default: next_state = WRITE;
               endcase
            end
         end
         MODE: begin
            vga_ms     = 1'b1;
            vga_din    = {7'b0, mode_q};
            next_state = IDLE;
         end
         WRITE: begin
            vga_wren   = 1'b1;
            vga_a      = wr_addr;
            vga_din    = wr_data;
            next_state = (wr_adv && col == LAST_COL && row == LAST_ROW) ? SCR_RD : IDLE;
         end
         SCR_RD: begin
            vga_a      = BASE_ADDR + cnt;
            next_state = SCR_WR;
         end
         SCR_WR: begin
            vga_wren   = 1'b1;
            vga_a      = BASE_ADDR + cnt - COLS_12;
            vga_din    = vga_dout;
            next_state = (cnt == LAST_CNT) ? FILL : SCR_RD;
         end
         FILL, CLEAR: begin
            vga_wren   = 1'b1;
            vga_a      = BASE_ADDR + cnt;
            vga_din    = BLANK;
            next_state = (cnt == LAST_CNT) ? IDLE : state;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst) begin
      if (!rst) begin
         row        <= '0;
         col        <= '0;
         cnt        <= '0;
         wr_addr    <= '0;
         wr_data    <= '0;
         wr_adv     <= 1'b0;
         clear_pend <= 1'b0;
         mode_pend  <= 1'b0;
         mode_q     <= 1'b0;
      end else begin
         // Pending flags drop when IDLE dispatches them; a request arriving
         // in that same cycle re-arms the flag so no pulse is lost.
         if (state == IDLE && clear_pend) clear_pend <= 1'b0;
         if (state == IDLE && !clear_pend && mode_pend) mode_pend <= 1'b0;
         if (clear_req) clear_pend <= 1'b1;
         if (mode_req) begin
            mode_pend <= 1'b1;
            mode_q    <= mode_val;
         end

         case (state)
            IDLE: begin
               if (clear_pend) begin
                  cnt <= '0;
               end else if (!mode_pend && accept) begin
                  case (char_data)
                     CH_CR: col <= '0;
                     CH_LF: begin
                        col <= '0;
                        if (row != LAST_ROW) row <= row + RW'(1);
                        else                 cnt <= COLS_12;
                     end
                     CH_BS: begin
                        if (col != '0) begin
                           col     <= col - CW'(1);
                           wr_addr <= BASE_ADDR + bs_pos;
                           wr_data <= BLANK;
                           wr_adv  <= 1'b0;
                        end
                     end
                     default: begin
                        wr_addr <= BASE_ADDR + cur_pos;
                        wr_data <= char_data;
                        wr_adv  <= 1'b1;
                     end
                  endcase
               end
            end
            WRITE: begin
               if (wr_adv) begin
                  if (col == LAST_COL) begin
                     col <= '0;
                     if (row != LAST_ROW) row <= row + RW'(1);
                     else                 cnt <= COLS_12;
                  end else begin
                     col <= col + CW'(1);
                  end
               end
            end
            SCR_WR: begin
               if (cnt == LAST_CNT) cnt <= FILL_START;
               else                 cnt <= cnt + 12'd1;
            end
            FILL: cnt <= cnt + 12'd1;
            CLEAR: begin
               cnt <= cnt + 12'd1;
               if (cnt == LAST_CNT) begin
                  row <= '0;
                  col <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_vga_console_writer.sv
// ============================================================================
// Module : tb_vga_console_writer
// Purpose: Directed self-checking bench for vga_console_writer with a small
//          behavioural model of the VGA text RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_console_writer;
   import vga_console_pkg::*;

   logic        clk_sys = 1'b0;
   logic        rst;
   logic        char_valid;
   logic [7:0]  char_data;
   logic        char_ready;
   logic        clear_req;
   logic        mode_req;
   logic        mode_val;
   logic        vga_ms;
   logic        vga_wren;
   logic [11:0] vga_a;
   logic [7:0]  vga_din;
   logic [7:0]  vga_dout;
   logic        busy;
   logic [3:0]  cursor_row;
   logic [4:0]  cursor_col;

   vga_console_writer dut (
      .clk_sys    (clk_sys),
      .rst        (rst),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_ready (char_ready),
      .clear_req  (clear_req),
      .mode_req   (mode_req),
      .mode_val   (mode_val),
      .vga_ms     (vga_ms),
      .vga_wren   (vga_wren),
      .vga_a      (vga_a),
      .vga_din    (vga_din),
      .vga_dout   (vga_dout),
      .busy       (busy),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col)
   );

   always #5 clk_sys = ~clk_sys;

   // VGA text RAM model: synchronous write, registered read data.
   logic [7:0]  mem [0:4095];
   int          wr_count = 0;
   int          both_hi  = 0;
   logic [11:0] last_a   = 12'h000;

   always @(posedge clk_sys) begin
      if (vga_wren) begin
         mem[vga_a] <= vga_din;
         wr_count   <= wr_count + 1;
         last_a     <= vga_a;
      end
      if (vga_wren && vga_ms) both_hi <= both_hi + 1;
      vga_dout <= mem[vga_a];
   end

   int checks = 0;
   int passed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      while (!char_ready && n < 5000) begin
         @(negedge clk_sys);
         n++;
      end
      check("send_ready", {31'b0, char_ready}, 32'd1);
      char_valid = 1'b1;
      char_data  = b;
      @(negedge clk_sys);
      char_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 5000) begin
         @(negedge clk_sys);
         n++;
      end
      check("idle_timeout", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      int wc;
      int busy_cyc;
      int bad;
      bit rdy_seen;

      rst        = 1'b0;
      char_valid = 1'b0;
      char_data  = 8'h00;
      clear_req  = 1'b0;
      mode_req   = 1'b0;
      mode_val   = 1'b0;
      repeat (3) @(negedge clk_sys);

      // Reset state
      check("rst_busy",  {31'b0, busy}, 0);
      check("rst_wren",  {31'b0, vga_wren}, 0);
      check("rst_ms",    {31'b0, vga_ms}, 0);
      check("rst_a",     {20'b0, vga_a}, 0);
      check("rst_din",   {24'b0, vga_din}, 0);
      check("rst_ready", {31'b0, char_ready}, 0);
      check("rst_row",   {28'b0, cursor_row}, 0);
      check("rst_col",   {27'b0, cursor_col}, 0);
      rst = 1'b1;
      @(negedge clk_sys);
      check("ready_after_rst", {31'b0, char_ready}, 1);

      // Single printable byte
      send(8'h41);
      check("a_wren", {31'b0, vga_wren}, 1);
      check("a_addr", {20'b0, vga_a}, 32'h000);
      check("a_din",  {24'b0, vga_din}, 32'h41);
      @(negedge clk_sys);
      check("a_ready", {31'b0, char_ready}, 1);
      check("a_row",   {28'b0, cursor_row}, 0);
      check("a_col",   {27'b0, cursor_col}, 1);

      // Carriage return: no RAM access, stays ready
      wc = wr_count;
      send(CH_CR);
      check("cr_ready", {31'b0, char_ready}, 1);
      check("cr_wren",  {31'b0, vga_wren}, 0);
      check("cr_col",   {27'b0, cursor_col}, 0);
      check("cr_nowr",  wr_count, wc);

      // Backspace at (0,5) and at (0,0)
      for (int i = 0; i < 5; i++) send(8'h31 + 8'(i));
      send(CH_BS);
      check("bs_wren", {31'b0, vga_wren}, 1);
      check("bs_addr", {20'b0, vga_a}, 32'h004);
      check("bs_din",  {24'b0, vga_din}, 32'h20);
      check("bs_col",  {27'b0, cursor_col}, 4);
      send(CH_CR);
      wc = wr_count;
      send(CH_BS);
      check("bs0_wren", {31'b0, vga_wren}, 0);
      repeat (3) @(negedge clk_sys);
      check("bs0_nowr", wr_count, wc);
      check("bs0_col",  {27'b0, cursor_col}, 0);

      // Fill rows 0..14 fully, row 15 up to col 30
      for (int r = 0; r < 15; r++) begin
         for (int c = 0; c < 32; c++) send(8'h30 + 8'(r));
         if (r == 0) begin
            wait_idle();
            check("row0_last_a", {20'b0, last_a}, 32'h01F);
            check("row0_wrap_row", {28'b0, cursor_row}, 1);
            check("row0_wrap_col", {27'b0, cursor_col}, 0);
         end
      end
      for (int c = 0; c < 31; c++) send(8'h3F);
      wait_idle();
      check("pre_lf_row", {28'b0, cursor_row}, 15);
      check("pre_lf_col", {27'b0, cursor_col}, 31);

      // Line feed on the last row scrolls
      send(CH_LF);
      busy_cyc = 0;
      rdy_seen = 1'b0;
      while (busy && busy_cyc < 5000) begin
         if (char_ready) rdy_seen = 1'b1;
         busy_cyc++;
         @(negedge clk_sys);
      end
      check("scroll_cycles", busy_cyc, 992);
      check("scroll_ready_low", {31'b0, rdy_seen}, 0);
      bad = 0;
      for (int a = 0; a < 14 * 32; a++)
         if (mem[a] !== 8'h31 + 8'(a / 32)) bad++;
      for (int a = 14 * 32; a < 14 * 32 + 31; a++)
         if (mem[a] !== 8'h3F) bad++;
      check("scroll_rows_moved", bad, 0);
      bad = 0;
      for (int a = 15 * 32; a < 16 * 32; a++)
         if (mem[a] !== 8'h20) bad++;
      check("scroll_last_blank", bad, 0);
      check("scroll_row", {28'b0, cursor_row}, 15);
      check("scroll_col", {27'b0, cursor_col}, 0);

      // Clear and mode requested together during a scroll
      send(CH_LF);
      repeat (10) @(negedge clk_sys);
      clear_req = 1'b1;
      mode_req  = 1'b1;
      mode_val  = 1'b1;
      @(negedge clk_sys);
      clear_req = 1'b0;
      mode_req  = 1'b0;
      mode_val  = 1'b0;
      wait_idle();
      check("pend_ready_low", {31'b0, char_ready}, 0);
      @(negedge clk_sys);
      bad = 0;
      for (int i = 0; i < 512; i++) begin
         if (!(vga_wren === 1'b1 && vga_a === 12'(i) && vga_din === 8'h20)) bad++;
         @(negedge clk_sys);
      end
      check("clear_writes", bad, 0);
      check("gap_ms", {31'b0, vga_ms}, 0);
      @(negedge clk_sys);
      check("mode_ms",   {31'b0, vga_ms}, 1);
      check("mode_din",  {24'b0, vga_din}, 32'h01);
      check("mode_wren", {31'b0, vga_wren}, 0);
      @(negedge clk_sys);
      check("post_mode_ready", {31'b0, char_ready}, 1);
      check("clear_row", {28'b0, cursor_row}, 0);
      check("clear_col", {27'b0, cursor_col}, 0);

      // Reset in the middle of a clear
      send(8'h5A);
      wait_idle();
      check("z_col", {27'b0, cursor_col}, 1);
      clear_req = 1'b1;
      @(negedge clk_sys);
      clear_req = 1'b0;
      repeat (20) @(negedge clk_sys);
      check("midclr_wren", {31'b0, vga_wren}, 1);
      rst = 1'b0;
      #1;
      check("abort_wren",  {31'b0, vga_wren}, 0);
      check("abort_ms",    {31'b0, vga_ms}, 0);
      check("abort_busy",  {31'b0, busy}, 0);
      check("abort_a",     {20'b0, vga_a}, 0);
      check("abort_din",   {24'b0, vga_din}, 0);
      check("abort_ready", {31'b0, char_ready}, 0);
      check("abort_row",   {28'b0, cursor_row}, 0);
      check("abort_col",   {27'b0, cursor_col}, 0);
      wc = wr_count;
      @(negedge clk_sys);
      rst = 1'b1;
      repeat (30) @(negedge clk_sys);
      check("rel_busy",  {31'b0, busy}, 0);
      check("rel_ready", {31'b0, char_ready}, 1);
      check("rel_nowr",  wr_count, wc);
      check("rel_row",   {28'b0, cursor_row}, 0);
      check("rel_col",   {27'b0, cursor_col}, 0);

      check("wren_ms_exclusive", both_hi, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/vga_console_writer.md
Name: vga_console_writer

Overview:
- CPU-side producer for the VGA text buffer: turns a byte stream of characters into writes on the VGA port (VGA_A/VGA_Din/VGA_WrEn/VGA_MS, reads via VGA_Dout).
- Maintains a cursor and interprets CR/LF/BS, wraps at end of line, and scrolls by copying rows up through the RAM port.
- Also clears the screen and sets the display mode register.
- Sits between a UART/CPU byte source and the VGA block, in the clk_sys domain.

Parameters:
- COLS, 32, characters per row; power of two.
- ROWS, 16, rows per screen.
- BASE_ADDR, 12'h000, VGA RAM address of row 0, col 0.
- BLANK, 8'h20, fill byte used for clear, scroll and backspace.

Ports:
- clk_sys  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- char_valid  in  1  char_data is offered.
- char_data  in  8  character or control code.
- char_ready  out  1  byte accepted when char_valid && char_ready.
- clear_req  in  1  one-cycle pulse requesting a screen clear.
- mode_req  in  1  one-cycle pulse requesting a mode write.
- mode_val  in  1  mode bit captured together with mode_req.
- vga_ms  out  1  mode-select strobe to the VGA block.
- vga_wren  out  1  RAM write enable.
- vga_a  out  12  RAM address.
- vga_din  out  8  RAM write data; bit 0 carries the mode during vga_ms.
- vga_dout  in  8  RAM read data, valid one cycle after the address is presented with vga_wren=0.
- busy  out  1  high in any state other than IDLE.
- cursor_row  out  $clog2(ROWS)  current row.
- cursor_col  out  $clog2(COLS)  current column.

Behaviour:
- Reset (rst=0) values: all outputs 0, cursor (0,0), pending flags cleared, state IDLE.
- char_ready = (state==IDLE) && !clear_pend && !mode_pend.
- clear_req and mode_req set pending flags (mode_val latched) in any state; pulses are never lost. A repeated request while pending collapses into one; the latest mode_val wins.
- IDLE priority: clear_pend > mode_pend > char handshake.
- MODE: one cycle with vga_ms=1, vga_din={7'b0,mode_val}, vga_wren=0; mode_pend cleared; return to IDLE.
- Printable byte (anything except 0x08/0x0A/0x0D), accepted at cycle N, goes to WRITE:
  - cycle N+1: vga_wren=1, vga_a=BASE_ADDR+row*COLS+col, vga_din=byte.
  - Then col+1. If col was COLS-1, perform a newline.
- 0x0D: col=0; no RAM access; char_ready stays high.
- 0x0A: newline.
- 0x08:
  - if col>0: col-1, then a WRITE of BLANK at the new position;
  - if col==0: no operation.
- Newline: col=0. If row<ROWS-1, row+1; else enter SCROLL and row stays ROWS-1.
- SCROLL, for src = COLS to COLS*ROWS-1, two cycles per byte:
  - SCR_RD: vga_a=BASE+src, vga_wren=0.
  - SCR_WR: vga_a=BASE+src-COLS, vga_din=vga_dout, vga_wren=1.
- FILL, after SCROLL: COLS cycles writing BLANK to the last row, ascending addresses.
- Total scroll occupancy is 2*COLS*(ROWS-1)+COLS cycles (992 at defaults); the bus is idle only in IDLE.
- CLEAR: COLS*ROWS consecutive writes of BLANK from BASE_ADDR ascending; cursor (0,0) on completion; clear_pend cleared on entry.
- A clear_req arriving mid-SCROLL/FILL is honoured after return to IDLE.
- Address arithmetic is 12-bit; BASE_ADDR + COLS*ROWS must be ≤ 4096 (elaboration check).
- vga_wren and vga_ms are never high in the same cycle.
- rst asserted mid-operation aborts immediately: outputs 0, RAM contents left as-is.

Decomposition:
- Shared package vga_console_pkg holds:
  - the state enum (IDLE, MODE, WRITE, SCR_RD, SCR_WR, FILL, CLEAR);
  - control-code constants CH_BS=8'h08, CH_LF=8'h0A, CH_CR=8'h0D.
- No sub-module: a single FSM with one address counter and a cursor register pair. Target is roughly 200 lines.

Test Plan:
- Reset then 'A'(8'h41) → one write at 12'h000 data 8'h41 one cycle after the handshake; cursor (0,1); char_ready high again the cycle after the write.
- 32 printable bytes on row 0 → last write at 12'h01F; cursor wraps to (1,0); no scroll.
- 16 rows filled (row r = byte 8'h30+r), then 0x0A → busy for 992 cycles:
  - RAM rows 0..14 hold 8'h31..8'h3F;
  - row 15 is all 8'h20;
  - cursor (15,0);
  - char_ready low throughout.
- Cursor (0,5), 0x08 → BLANK written at 12'h004, cursor (0,4). At (0,0), 0x08 → no vga_wren.
- clear_req and mode_req (mode_val=1) pulsed in the same cycle during a scroll:
  - after the scroll, 512 BLANK writes from 12'h000;
  - then one vga_ms cycle with vga_din=8'h01;
  - then char_ready rises.
- rst driven low mid-CLEAR → all outputs 0 immediately. After release: state IDLE, cursor (0,0), char_ready=1, no further writes.
